// File: rtl/hack_mem_read_ctrl_pkg.sv
// Shared definitions for the Hack data-memory read path:
// region boundaries, mux select encodings and read FSM states.
package hack_mem_read_ctrl_pkg;

  localparam logic [14:0] RAM_BASE     = 15'h0000;
  localparam logic [14:0] RAM_LAST     = 15'h3FFF;
  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam logic [14:0] SCREEN_LAST  = 15'h5FFF;
  localparam logic [14:0] KBD_ADDR_DEF = 15'h6000;

  localparam logic [1:0] SEL_RAM    = 2'd0;
  localparam logic [1:0] SEL_SCREEN = 2'd1;
  localparam logic [1:0] SEL_KBD    = 2'd2;
  localparam logic [1:0] SEL_PER    = 2'd3;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WAIT_PER = 2'd2,
    RESP     = 2'd3
  } state_t;

endpackage

// File: rtl/hack_addr_decode.sv
// Combinational Hack address decoder: addr_i[14:0] -> Mux4Way16 sel_o.
// Ports: addr_i (word address), sel_o (RAM/screen/keyboard/peripheral).
module hack_addr_decode
  import hack_mem_read_ctrl_pkg::*;
#(
  parameter logic [14:0] KBD_ADDR = KBD_ADDR_DEF
) (
  input  logic [14:0] addr_i,
  output logic [1:0]  sel_o
);

  // Conditions are mutually exclusive; the keyboard
  // match is restricted to above the screen window.
  always_comb begin
    sel_o = SEL_PER;
    unique case (1'b1)
      (addr_i <= RAM_LAST): sel_o = SEL_RAM;
      (addr_i >= SCREEN_BASE && addr_i <= SCREEN_LAST):
        sel_o = SEL_SCREEN;
      (addr_i == KBD_ADDR && addr_i > SCREEN_LAST):
        sel_o = SEL_KBD;
      default: sel_o = SEL_PER;
    endcase
  end

endmodule

// File: rtl/hack_mem_read_ctrl.sv
// Hack data-memory read controller driving a Mux4Way16 select.
// Ports: req/addr/ready in, sel/mux_out to mux, per_req/per_ack, rdata/rvalid/err out.
module hack_mem_read_ctrl
  import hack_mem_read_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [14:0] KBD_ADDR = KBD_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [14:0] addr,
  output logic        ready,
  output logic [1:0]  sel,
  input  logic [15:0] mux_out,
  output logic        per_req,
  input  logic        per_ack,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic        err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [1:0]         dec_sel;

  hack_addr_decode #(
    .KBD_ADDR (KBD_ADDR)
  ) u_dec (
    .addr_i (addr),
    .sel_o  (dec_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= SEL_RAM;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Counter holds remaining wait cycles; the cycle in
  // which it reads zero is the capture/timeout cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          sel_d = dec_sel;
          err_d = 1'b0;
          if (dec_sel == SEL_PER) begin
            state_d = WAIT_PER;
            cnt_d   = CNT_W'(TIMEOUT - 1);
          end else begin
            state_d = WAIT_MEM;
            cnt_d   = (dec_sel == SEL_KBD) ?
                      '0 : CNT_W'(MEM_LAT);
          end
        end
      end
      WAIT_MEM: begin
        if (cnt_q == '0) begin
          rdata_d = mux_out;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_PER: begin
        // Ack in the last window cycle still wins.
        if (per_ack) begin
          rdata_d = mux_out;
          state_d = RESP;
        end else if (cnt_q == '0) begin
          rdata_d = 16'hFFFF;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_q == IDLE);
    rvalid  = (state_q == RESP);
    err     = (state_q == RESP) && err_q;
    per_req = (state_q == WAIT_PER);
    sel     = sel_q;
    rdata   = rdata_q;
  end

endmodule
